// File: rtl/matrix_receiver_if.sv
// Panel-side shift/latch bus plus frame-store readback and status.
// master drives the panel signals, slave is the receiver.
interface matrix_receiver_if #(
  parameter int COLS = 32,
  parameter int ROWS = 16
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int SW = $clog2(COLS + 1);

  logic          sclk;
  logic [2:0]    LED1;
  logic [2:0]    LED2;
  logic          lat;
  logic [RW-1:0] row_addr;
  logic          oe_n;
  logic          rd_half;
  logic [RW-1:0] rd_row;
  logic [CW-1:0] rd_col;
  logic [2:0]    rd_pixel;
  logic [SW-1:0] shift_count;
  logic          overrun;
  logic          short_row;
  logic [ROWS-1:0] row_valid;
  logic          frame_done;
  logic [7:0]    frame_count;
  logic          disp_on;

  modport master (
    output sclk, LED1, LED2, lat, row_addr, oe_n,
    output rd_half, rd_row, rd_col,
    input  rd_pixel, shift_count, overrun, short_row,
    input  row_valid, frame_done, frame_count, disp_on
  );

  modport slave (
    input  sclk, LED1, LED2, lat, row_addr, oe_n,
    input  rd_half, rd_row, rd_col,
    output rd_pixel, shift_count, overrun, short_row,
    output row_valid, frame_done, frame_count, disp_on
  );
endinterface

// File: rtl/matrix_receiver.sv
// Receives a HUB75-style two-half panel stream into a frame store.
// Tracks row completion, shift errors and provides pixel readback.
module matrix_receiver #(
  parameter int COLS = 32,
  parameter int ROWS = 16
) (
  input logic clk,
  input logic reset,
  matrix_receiver_if.slave bus
);
  localparam int SW = $clog2(COLS + 1);
  localparam logic [SW-1:0] FULL = SW'(COLS);

  typedef logic [COLS-1:0][2:0] line_t;

  logic          sclk_q;
  logic          lat_q;
  logic          sclk_edge;
  logic          lat_edge;
  line_t         up_sr;
  line_t         lo_sr;
  line_t         up_nxt;
  line_t         lo_nxt;
  line_t         frame [2][ROWS];
  logic [SW-1:0] cnt_shift;
  logic [ROWS-1:0] rv_set;
  logic          row_done;

  assign sclk_edge = bus.sclk & ~sclk_q;
  assign lat_edge  = bus.lat & ~lat_q;

  // Post-shift view of this cycle; a coincident latch captures it.
  always_comb begin
    up_nxt    = up_sr;
    lo_nxt    = lo_sr;
    cnt_shift = bus.shift_count;
    if (sclk_edge) begin
      up_nxt = {up_sr[COLS-2:0], bus.LED1};
      lo_nxt = {lo_sr[COLS-2:0], bus.LED2};
      if (bus.shift_count != FULL)
        cnt_shift = bus.shift_count + 1'b1;
    end
    rv_set = bus.row_valid;
    rv_set[bus.row_addr] = 1'b1;
    row_done = &rv_set;
  end

  // Edge-detect copies and the two shift registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_q <= 1'b1;
      lat_q  <= 1'b1;
      up_sr  <= '0;
      lo_sr  <= '0;
    end else begin
      sclk_q <= bus.sclk;
      lat_q  <= bus.lat;
      up_sr  <= up_nxt;
      lo_sr  <= lo_nxt;
    end
  end

  // Shift counter and sticky error flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.shift_count <= '0;
      bus.overrun     <= 1'b0;
      bus.short_row   <= 1'b0;
    end else begin
      if (sclk_edge && bus.shift_count == FULL)
        bus.overrun <= 1'b1;
      if (lat_edge) begin
        bus.shift_count <= '0;
        if (cnt_shift != FULL)
          bus.short_row <= 1'b1;
      end else begin
        bus.shift_count <= cnt_shift;
      end
    end
  end

  // Frame store writes and write-first registered readback.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int h = 0; h < 2; h++)
        for (int r = 0; r < ROWS; r++)
          frame[h][r] <= '0;
      bus.rd_pixel <= '0;
    end else begin
      if (lat_edge) begin
        frame[0][bus.row_addr] <= up_nxt;
        frame[1][bus.row_addr] <= lo_nxt;
      end
      if (lat_edge && bus.rd_row == bus.row_addr)
        bus.rd_pixel <= bus.rd_half ? lo_nxt[bus.rd_col]
                                    : up_nxt[bus.rd_col];
      else
        bus.rd_pixel <= frame[bus.rd_half][bus.rd_row][bus.rd_col];
    end
  end

  // Row bookkeeping, frame completion pulse and display enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.row_valid   <= '0;
      bus.frame_done  <= 1'b0;
      bus.frame_count <= '0;
      bus.disp_on     <= 1'b0;
    end else begin
      bus.frame_done <= 1'b0;
      bus.disp_on    <= ~bus.oe_n;
      if (lat_edge) begin
        if (row_done) begin
          bus.row_valid   <= '0;
          bus.frame_done  <= 1'b1;
          bus.frame_count <= bus.frame_count + 8'd1;
        end else begin
          bus.row_valid <= rv_set;
        end
      end
    end
  end
endmodule

// File: tb/tb_matrix_receiver.sv
// Self-checking bench for matrix_receiver.
// Readback expectations flow through a scoreboard queue.
module tb_matrix_receiver;
  logic clk = 1'b0;
  logic reset = 1'b1;

  matrix_receiver_if bus ();

  matrix_receiver dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       h;
    logic [3:0] r;
    logic [4:0] c;
    logic [2:0] e;
  } rd_vec_t;

  int checks = 0;
  int errors = 0;
  int fd_pulses = 0;
  logic [2:0] exp_q [$];
  rd_vec_t vecs [7];

  logic        fd_at;
  logic [15:0] rv_at;
  logic [7:0]  fc_at;
  logic [2:0]  rp_at;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    if (bus.frame_done === 1'b1) fd_pulses++;
  endtask

  task automatic shift(input logic [2:0] a, input logic [2:0] b);
    bus.LED1 = a;
    bus.LED2 = b;
    bus.sclk = 1'b1;
    cyc();
    bus.sclk = 1'b0;
    cyc();
  endtask

  task automatic latch(input logic [3:0] r);
    bus.row_addr = r;
    bus.lat = 1'b1;
    cyc();
    fd_at = bus.frame_done;
    rv_at = bus.row_valid;
    fc_at = bus.frame_count;
    rp_at = bus.rd_pixel;
    bus.lat = 1'b0;
    cyc();
  endtask

  task automatic rd(input logic h, input logic [3:0] r,
                    input logic [4:0] c, input logic [2:0] e,
                    input string nm);
    logic [2:0] x;
    bus.rd_half = h;
    bus.rd_row  = r;
    bus.rd_col  = c;
    exp_q.push_back(e);
    cyc();
    x = exp_q.pop_front();
    chk(nm, {29'd0, bus.rd_pixel}, {29'd0, x});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
  endtask

  initial begin
    vecs[0] = '{1'b0, 4'd3, 5'd31, 3'd0};
    vecs[1] = '{1'b0, 4'd3, 5'd0,  3'd7};
    vecs[2] = '{1'b0, 4'd3, 5'd24, 3'd7};
    vecs[3] = '{1'b0, 4'd3, 5'd20, 3'd3};
    vecs[4] = '{1'b1, 4'd3, 5'd0,  3'd7};
    vecs[5] = '{1'b1, 4'd3, 5'd17, 3'd7};
    vecs[6] = '{1'b0, 4'd4, 5'd5,  3'd0};

    bus.sclk = 1'b0;
    bus.lat = 1'b0;
    bus.LED1 = '0;
    bus.LED2 = '0;
    bus.row_addr = '0;
    bus.oe_n = 1'b0;
    bus.rd_half = 1'b0;
    bus.rd_row = '0;
    bus.rd_col = '0;

    cyc();
    cyc();
    chk("rst_count", bus.shift_count, 0);
    chk("rst_overrun", bus.overrun, 0);
    chk("rst_short", bus.short_row, 0);
    chk("rst_rowvalid", bus.row_valid, 0);
    chk("rst_fcount", bus.frame_count, 0);
    chk("rst_fdone", bus.frame_done, 0);
    chk("rst_rdpix", bus.rd_pixel, 0);
    chk("rst_disp", bus.disp_on, 0);
    reset = 1'b0;
    cyc();
    chk("disp_on", bus.disp_on, 1);
    bus.oe_n = 1'b1;
    cyc();
    chk("disp_off", bus.disp_on, 0);

    for (int k = 0; k < 32; k++) shift(3'(k % 8), 3'd7);
    chk("full_count", bus.shift_count, 32);
    latch(4'd3);
    chk("full_cnt_clr", bus.shift_count, 0);
    chk("full_overrun", bus.overrun, 0);
    chk("full_short", bus.short_row, 0);
    chk("full_rv", bus.row_valid, 16'h0008);
    for (int i = 0; i < 7; i++)
      rd(vecs[i].h, vecs[i].r, vecs[i].c, vecs[i].e, "vec_rd");

    for (int k = 0; k < 33; k++) begin
      shift(3'(k % 8), 3'(7 - (k % 8)));
      if (k == 31) chk("pre_overrun", bus.overrun, 0);
    end
    chk("ovr_count", bus.shift_count, 32);
    chk("ovr_flag", bus.overrun, 1);
    bus.rd_half = 1'b0;
    bus.rd_row = 4'd4;
    bus.rd_col = 5'd31;
    latch(4'd4);
    chk("write_first", rp_at, 1);
    chk("ovr_short", bus.short_row, 0);
    rd(1'b0, 4'd4, 5'd0, 3'd0, "ovr_col0");
    rd(1'b1, 4'd4, 5'd0, 3'd7, "ovr_lo_col0");
    rd(1'b1, 4'd4, 5'd31, 3'd6, "ovr_lo_col31");

    do_reset();
    chk("post_rst_ovr", bus.overrun, 0);
    rd(1'b0, 4'd3, 5'd0, 3'd0, "frame_cleared");
    for (int k = 0; k < 10; k++) shift(3'(k % 8), 3'd2);
    latch(4'd7);
    chk("short_flag", bus.short_row, 1);
    chk("short_rv", bus.row_valid, 16'h0080);
    chk("short_cnt", bus.shift_count, 0);
    rd(1'b0, 4'd7, 5'd0, 3'd1, "short_col0");
    rd(1'b0, 4'd7, 5'd9, 3'd0, "short_col9");

    do_reset();
    for (int k = 0; k < 31; k++) shift(3'(k % 8), 3'd5);
    bus.LED1 = 3'd7;
    bus.LED2 = 3'd1;
    bus.row_addr = 4'd2;
    bus.sclk = 1'b1;
    bus.lat = 1'b1;
    cyc();
    bus.sclk = 1'b0;
    bus.lat = 1'b0;
    cyc();
    chk("same_short", bus.short_row, 0);
    chk("same_cnt", bus.shift_count, 0);
    chk("same_ovr", bus.overrun, 0);
    rd(1'b0, 4'd2, 5'd0, 3'd7, "same_col0");
    rd(1'b0, 4'd2, 5'd31, 3'd0, "same_col31");
    rd(1'b1, 4'd2, 5'd0, 3'd1, "same_lo_col0");
    latch(4'd6);
    chk("relatch_short", bus.short_row, 1);
    rd(1'b0, 4'd6, 5'd0, 3'd7, "sr_kept");

    do_reset();
    fd_pulses = 0;
    for (int r = 0; r < 16; r++) begin
      latch(4'(r));
      if (r < 15) chk("no_done", fd_at, 0);
      if (r == 5) begin
        latch(4'd5);
        chk("repeat_done", fd_at, 0);
        chk("repeat_rv", rv_at, 16'h003f);
      end
    end
    chk("done_pulse", fd_at, 1);
    chk("done_rv", rv_at, 0);
    chk("done_fc", fc_at, 1);
    chk("done_one_cycle", bus.frame_done, 0);
    chk("done_count", fd_pulses, 1);

    for (int k = 0; k < 5; k++) shift(3'd3, 3'd3);
    bus.sclk = 1'b1;
    bus.lat = 1'b1;
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
    cyc();
    chk("hold_cnt", bus.shift_count, 0);
    chk("hold_rv", bus.row_valid, 0);
    bus.sclk = 1'b0;
    bus.lat = 1'b0;
    cyc();
    chk("hold_low", bus.shift_count, 0);
    bus.sclk = 1'b1;
    cyc();
    chk("first_edge", bus.shift_count, 1);
    bus.sclk = 1'b0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
